// File: rtl/nes_pad_responder.sv
`timescale 1ns/1ps
// Device side of the serial game-pad protocol: snapshots eight active-low buttons on
// a host latch and shifts them out MSB first on each host pulse rising edge.
module nes_pad_responder #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       latch,
    input  logic       pulse,
    input  logic [7:0] buttons,
    output logic       data,
    output logic       busy,
    output logic       frame_done
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LATCHING = 2'b01,
        SHIFTING = 2'b10
    } state_t;

    // Two-flop synchronizers plus a delayed copy for edge detection.
    logic latch_meta_reg, latch_s_reg, latch_d_reg;
    logic pulse_meta_reg, pulse_s_reg, pulse_d_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            latch_meta_reg <= 1'b1;
            latch_s_reg    <= 1'b1;
            latch_d_reg    <= 1'b1;
            pulse_meta_reg <= 1'b0;
            pulse_s_reg    <= 1'b0;
            pulse_d_reg    <= 1'b0;
        end else begin
            latch_meta_reg <= latch;
            latch_s_reg    <= latch_meta_reg;
            latch_d_reg    <= latch_s_reg;
            pulse_meta_reg <= pulse;
            pulse_s_reg    <= pulse_meta_reg;
            pulse_d_reg    <= pulse_s_reg;
        end
    end

    logic latch_fall, latch_rise, pulse_rise;

    assign latch_fall = latch_d_reg & ~latch_s_reg;
    assign latch_rise = ~latch_d_reg & latch_s_reg;
    assign pulse_rise = ~pulse_d_reg & pulse_s_reg;

    state_t           state_reg, state_next;
    logic [7:0]       shreg_reg, shreg_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             frame_done_reg, frame_done_next;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= IDLE;
            shreg_reg      <= 8'hFF;
            bit_cnt_reg    <= 4'd0;
            tmo_cnt_reg    <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            bit_cnt_reg    <= bit_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shreg_next      = shreg_reg;
        bit_cnt_next    = bit_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        frame_done_next = 1'b0;

        case (state_reg)
            IDLE: begin
                shreg_next = 8'hFF;
                if (latch_fall) begin
                    shreg_next = buttons;
                    state_next = LATCHING;
                end
            end

            LATCHING: begin
                // Keep resampling so the last value before latch release is sent.
                shreg_next = buttons;
                if (latch_rise) begin
                    shreg_next   = shreg_reg;
                    bit_cnt_next = 4'd0;
                    tmo_cnt_next = '0;
                    state_next   = SHIFTING;
                end
            end

            SHIFTING: begin
                if (latch_fall) begin
                    shreg_next = buttons;
                    state_next = LATCHING;
                end else if (latch_rise) begin
                    // Only reachable through a glitch; treat as activity, not a shift.
                    tmo_cnt_next = '0;
                end else if (pulse_rise) begin
                    tmo_cnt_next = '0;
                    if (bit_cnt_reg == 4'd7) begin
                        shreg_next      = 8'hFF;
                        bit_cnt_next    = 4'd0;
                        frame_done_next = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        shreg_next   = {shreg_reg[6:0], 1'b1};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    shreg_next   = 8'hFF;
                    bit_cnt_next = 4'd0;
                    tmo_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_ONE;
                end
            end

            default: begin
                shreg_next   = 8'hFF;
                bit_cnt_next = 4'd0;
                tmo_cnt_next = '0;
                state_next   = IDLE;
            end
        endcase
    end

    assign data       = shreg_reg[7];
    assign busy       = (state_reg == LATCHING) || (state_reg == SHIFTING);
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_nes_pad_responder.sv
`timescale 1ns/1ps
// Directed bench for nes_pad_responder: table of whole frames plus hand-written
// sequences for timeout, abort, stray pulses, simultaneous edges and mid-frame reset.
module tb_nes_pad_responder;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       latch = 1'b1;
    logic       pulse = 1'b0;
    logic [7:0] buttons = 8'hFF;
    logic       data, busy, frame_done;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    nes_pad_responder #(.TIMEOUT_CYCLES(100)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .latch      (latch),
        .pulse      (pulse),
        .buttons    (buttons),
        .data       (data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_count++;
    end

    typedef struct {
        logic [7:0] b_fall;
        logic [7:0] b_release;
        logic [7:0] b_shift;
        logic [7:0] expv;
    } vec_t;

    vec_t vecs[4];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic one_pulse();
        pulse = 1'b1;
        tick(30);
        pulse = 1'b0;
        tick(30);
    endtask

    task automatic start_frame(input logic [7:0] btn);
        buttons = btn;
        latch = 1'b0;
        tick(60);
        latch = 1'b1;
        tick(30);
    endtask

    // Eight pulses; bits 6..0 checked at mid-high of pulses 1..7, end of frame at the 8th.
    task automatic pulse_run(input logic [7:0] expv, input string tag);
        for (int i = 1; i <= 8; i++) begin
            pulse = 1'b1;
            tick(3);
            if (i == 8) begin
                check($sformatf("%s end data", tag), data, 1'b1);
                check($sformatf("%s frame_done", tag), frame_done, 1'b1);
                check($sformatf("%s end busy", tag), busy, 1'b0);
                tick(1);
                check($sformatf("%s frame_done 1cyc", tag), frame_done, 1'b0);
                tick(11);
            end else begin
                tick(12);
                check($sformatf("%s bit%0d", tag, 7 - i), data, expv[7 - i]);
            end
            tick(15);
            pulse = 1'b0;
            tick(30);
        end
    endtask

    task automatic full_frame(input logic [7:0] b_fall, input logic [7:0] b_release,
                              input logic [7:0] b_shift, input logic [7:0] expv,
                              input string tag);
        int fd0;
        fd0 = fd_count;
        buttons = b_fall;
        latch = 1'b0;
        tick(2);
        check($sformatf("%s busy before latch seen", tag), busy, 1'b0);
        tick(1);
        check($sformatf("%s busy latching", tag), busy, 1'b1);
        check($sformatf("%s data latching", tag), data, b_fall[7]);
        tick(27);
        buttons = b_release;
        tick(30);
        latch = 1'b1;
        tick(3);
        check($sformatf("%s bit7", tag), data, expv[7]);
        buttons = b_shift;
        tick(27);
        pulse_run(expv, tag);
        check($sformatf("%s frame_done count", tag), 8'(fd_count - fd0), 8'd1);
    endtask

    initial begin
        int fd0;
        vecs[0] = '{8'h69, 8'h69, 8'h69, 8'h69};   // normal frame, 0110_1001
        vecs[1] = '{8'hFF, 8'h00, 8'hAA, 8'h00};   // snapshot is the value at release
        vecs[2] = '{8'hA5, 8'hA5, 8'h5A, 8'hA5};
        vecs[3] = '{8'h7E, 8'h81, 8'h00, 8'h81};

        // Reset state
        #12;
        check("reset data", data, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset frame_done", frame_done, 1'b0);
        #11;
        n_rst = 1'b1;
        tick(3);

        // Stray pulses with no latch
        for (int i = 0; i < 5; i++) begin
            pulse = 1'b1;
            tick(15);
            check($sformatf("stray%0d data", i), data, 1'b1);
            check($sformatf("stray%0d busy", i), busy, 1'b0);
            tick(15);
            pulse = 1'b0;
            tick(30);
        end

        // Table of full frames
        for (int v = 0; v < 4; v++) begin
            full_frame(vecs[v].b_fall, vecs[v].b_release, vecs[v].b_shift, vecs[v].expv,
                       $sformatf("vec%0d", v));
        end

        // Timeout after three pulses: E0 shifted three times leaves a 0 on data
        fd0 = fd_count;
        start_frame(8'hE0);
        one_pulse();
        one_pulse();
        pulse = 1'b1;
        tick(3);
        check("tmo busy after 3rd", busy, 1'b1);
        tick(27);
        pulse = 1'b0;
        tick(72);
        check("tmo busy at 99", busy, 1'b1);
        check("tmo data at 99", data, 1'b0);
        tick(1);
        check("tmo busy at 100", busy, 1'b0);
        check("tmo data at 100", data, 1'b1);
        check("tmo no frame_done", 8'(fd_count - fd0), 8'd0);
        tick(20);
        full_frame(8'h96, 8'h96, 8'h96, 8'h96, "post_tmo");

        // Abort after four pulses, relatch with a new snapshot
        fd0 = fd_count;
        start_frame(8'h0F);
        for (int i = 0; i < 4; i++) one_pulse();
        check("abort data before", data, 1'b1);
        buttons = 8'h5A;
        latch = 1'b0;
        tick(2);
        check("abort data latency", data, 1'b1);
        tick(1);
        check("abort busy", busy, 1'b1);
        check("abort data relatch", data, 1'b0);
        tick(57);
        latch = 1'b1;
        tick(3);
        check("abort bit7", data, 1'b0);
        tick(27);
        pulse_run(8'h5A, "abort");
        check("abort frame_done count", 8'(fd_count - fd0), 8'd1);

        // Latch release and pulse rise on the same edge: latch wins
        buttons = 8'hB4;
        latch = 1'b0;
        tick(60);
        latch = 1'b1;
        pulse = 1'b1;
        tick(3);
        check("simul busy", busy, 1'b1);
        check("simul bit7 kept", data, 1'b1);
        tick(27);
        pulse = 1'b0;
        tick(30);
        pulse_run(8'hB4, "simul");

        // Asynchronous reset between clock edges mid-frame
        start_frame(8'h00);
        for (int i = 0; i < 3; i++) one_pulse();
        check("rst pre data", data, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        check("rst async data", data, 1'b1);
        check("rst async busy", busy, 1'b0);
        tick(3);
        n_rst = 1'b1;
        tick(3);
        full_frame(8'hC3, 8'hC3, 8'h3C, 8'hC3, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
